// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit for the 32-bit datapath.
// One state register; every strobe is a combinational decode of (state, IR).
module control_sequencer #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_run,
    input  logic             i_mem_ready,
    input  logic [31:0]      i_ir,
    output logic [NREGS-1:0] o_rin,
    output logic [NREGS-1:0] o_rout,
    output logic [OPW-1:0]   o_alu_op,
    output logic             o_pcout,
    output logic             o_zhighout,
    output logic             o_zlowout,
    output logic             o_mdrout,
    output logic             o_hiout,
    output logic             o_loout,
    output logic             o_pcin,
    output logic             o_marin,
    output logic             o_mdrin,
    output logic             o_irin,
    output logic             o_yin,
    output logic             o_zin,
    output logic             o_hiin,
    output logic             o_loin,
    output logic             o_incpc,
    output logic             o_read,
    output logic             o_done,
    output logic             o_halted,
    output logic             o_illegal,
    output logic [3:0]       o_step
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_NEXT = 4'd8,
        S_HALT = 4'd9
    } state_t;
    typedef enum logic [2:0] {C_A, C_M, C_U, C_N, C_H, C_X} cls_t;
    localparam logic [NREGS-1:0] ONE = NREGS'(1);
    state_t         r_state;
    state_t         w_next;
    logic           r_illegal;
    logic           w_set_ill;
    cls_t           w_cls;
    logic [OPW-1:0] w_op;
    logic [3:0]     w_ra;
    logic [3:0]     w_rb;
    logic [3:0]     w_rc;
    logic           w_unused;
    assign w_op     = i_ir[31 -: OPW];
    assign w_ra     = i_ir[26:23];
    assign w_rb     = i_ir[22:19];
    assign w_rc     = i_ir[18:15];
    assign w_unused = ^i_ir[14:0];
    assign w_cls = (w_op >= OPW'(3) && w_op <= OPW'(10))  ? C_A :
                   (w_op == OPW'(15) || w_op == OPW'(16)) ? C_M :
                   (w_op == OPW'(17) || w_op == OPW'(18)) ? C_U :
                   (w_op == OPW'(26))                     ? C_N :
                   (w_op == OPW'(27))                     ? C_H : C_X;
    assign o_halted  = (r_state == S_HALT);
    assign o_illegal = r_illegal;
    assign o_step    = r_state;
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_ill)
                r_illegal <= 1'b1;
        end
    end
    always_comb begin
        w_next     = r_state;
        w_set_ill  = 1'b0;
        o_rin      = '0;
        o_rout     = '0;
        o_alu_op   = '0;
        o_pcout    = 1'b0;
        o_zhighout = 1'b0;
        o_zlowout  = 1'b0;
        o_mdrout   = 1'b0;
        o_hiout    = 1'b0;
        o_loout    = 1'b0;
        o_pcin     = 1'b0;
        o_marin    = 1'b0;
        o_mdrin    = 1'b0;
        o_irin     = 1'b0;
        o_yin      = 1'b0;
        o_zin      = 1'b0;
        o_hiin     = 1'b0;
        o_loin     = 1'b0;
        o_incpc    = 1'b0;
        o_read     = 1'b0;
        o_done     = 1'b0;
        case (r_state)
            S_IDLE: w_next = i_run ? S_T0 : S_IDLE;
            S_T0: begin
                o_pcout = 1'b1;
                o_marin = 1'b1;
                o_incpc = 1'b1;
                o_zin   = 1'b1;
                w_next  = S_T1;
            end
            S_T1: begin
                // PC strobes repeat each wait cycle; Z still holds PC+1 so this is harmless
                o_zlowout = 1'b1;
                o_pcin    = 1'b1;
                o_read    = 1'b1;
                o_mdrin   = 1'b1;
                w_next    = i_mem_ready ? S_T2 : S_T1;
            end
            S_T2: begin
                o_mdrout = 1'b1;
                o_irin   = 1'b1;
                w_next   = S_T3;
            end
            S_T3: begin
                case (w_cls)
                    C_A: begin
                        o_rout = ONE << w_rb;
                        o_yin  = 1'b1;
                        w_next = S_T4;
                    end
                    C_M: begin
                        o_rout = ONE << w_ra;
                        o_yin  = 1'b1;
                        w_next = S_T4;
                    end
                    C_U: begin
                        o_rout   = ONE << w_rb;
                        o_alu_op = w_op;
                        o_zin    = 1'b1;
                        w_next   = S_T4;
                    end
                    C_N: begin
                        o_done = 1'b1;
                        w_next = S_NEXT;
                    end
                    C_H: w_next = S_HALT;
                    default: begin
                        w_set_ill = 1'b1;
                        w_next    = S_HALT;
                    end
                endcase
            end
            S_T4: begin
                w_next = S_NEXT;
                case (w_cls)
                    C_A: begin
                        o_rout   = ONE << w_rc;
                        o_alu_op = w_op;
                        o_zin    = 1'b1;
                        w_next   = S_T5;
                    end
                    C_M: begin
                        o_rout   = ONE << w_rb;
                        o_alu_op = w_op;
                        o_zin    = 1'b1;
                        w_next   = S_T5;
                    end
                    C_U: begin
                        o_zlowout = 1'b1;
                        o_rin     = ONE << w_ra;
                        o_done    = 1'b1;
                    end
                    default: w_next = S_NEXT;
                endcase
            end
            S_T5: begin
                w_next = S_NEXT;
                case (w_cls)
                    C_A: begin
                        o_zlowout = 1'b1;
                        o_rin     = ONE << w_ra;
                        o_done    = 1'b1;
                    end
                    C_M: begin
                        o_zlowout = 1'b1;
                        o_loin    = 1'b1;
                        w_next    = S_T6;
                    end
                    default: w_next = S_NEXT;
                endcase
            end
            S_T6: begin
                o_zhighout = 1'b1;
                o_hiin     = 1'b1;
                o_done     = 1'b1;
                w_next     = S_NEXT;
            end
            S_NEXT: w_next = i_run ? S_T0 : S_IDLE;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized bench comparing every cycle's strobes against a
// queue of expected cycles built from the instruction-class step tables.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        mrdy = 1'b0;
    logic [31:0] ir = '0;
    logic [15:0] rin, rout;
    logic [4:0]  alu_op;
    logic pcout, zhighout, zlowout, mdrout, hiout, loout;
    logic pcin, marin, mdrin, irin, yin, zin, hiin, loin;
    logic incpc, read, done, halted, illegal;
    logic [3:0]  step;
    int checks = 0;
    int errors = 0;
    int last_lat = 0;
    int rd_cnt = 0;
    localparam int PCOUT = 16, ZHI = 15, ZLO = 14, MDROUT = 13, HIOUT = 12, LOOUT = 11;
    localparam int PCIN = 10, MARIN = 9, MDRIN = 8, IRIN = 7, YIN = 6, ZIN = 5;
    localparam int HIIN = 4, LOIN = 3, INCPC = 2, READ = 1, DONE = 0;
    localparam logic [31:0] IR_AND = 32'h2891_8000;
    localparam logic [31:0] IR_MUL = 32'h7891_8000;
    localparam logic [31:0] IR_NEG = 32'h8891_8000;
    localparam logic [31:0] IR_NOP = 32'hD000_0000;
    typedef struct packed {
        logic        run;
        logic        mrdy;
        logic [31:0] ir;
        logic [16:0] f;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
        logic        halted;
        logic        ill;
    } cyc_t;
    cyc_t exp_q[$];
    control_sequencer dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_run(run), .i_mem_ready(mrdy), .i_ir(ir),
        .o_rin(rin), .o_rout(rout), .o_alu_op(alu_op),
        .o_pcout(pcout), .o_zhighout(zhighout), .o_zlowout(zlowout), .o_mdrout(mdrout),
        .o_hiout(hiout), .o_loout(loout), .o_pcin(pcin), .o_marin(marin), .o_mdrin(mdrin),
        .o_irin(irin), .o_yin(yin), .o_zin(zin), .o_hiin(hiin), .o_loin(loin),
        .o_incpc(incpc), .o_read(read), .o_done(done), .o_halted(halted),
        .o_illegal(illegal), .o_step(step)
    );
    always #5 clk = ~clk;
    function automatic logic [16:0] flags();
        return {pcout, zhighout, zlowout, mdrout, hiout, loout, pcin, marin, mdrin,
                irin, yin, zin, hiin, loin, incpc, read, done};
    endfunction
    function automatic logic [55:0] all_out();
        return {flags(), rin, rout, alu_op, halted, illegal};
    endfunction
    function automatic cyc_t blk(logic r, logic [31:0] i);
        cyc_t e;
        e = '0;
        e.run = r;
        e.mrdy = 1'($urandom);
        e.ir = i;
        return e;
    endfunction
    function automatic int cls(logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd10) return 0;
        if (op == 5'd15 || op == 5'd16) return 1;
        if (op == 5'd17 || op == 5'd18) return 2;
        if (op == 5'd26) return 3;
        if (op == 5'd27) return 4;
        return 5;
    endfunction
    task automatic push_idle(input int n, input logic r);
        for (int k = 0; k < n; k++) exp_q.push_back(blk(r, $urandom));
    endtask
    task automatic push_halt(input int n, input logic ill);
        cyc_t e;
        for (int k = 0; k < n; k++) begin
            e = blk(1'($urandom), $urandom);
            e.halted = 1'b1;
            e.ill = ill;
            exp_q.push_back(e);
        end
    endtask
    // Fetch ignores IR (random junk until T3); execute steps follow the class tables.
    task automatic add_instr(input logic [31:0] i, input int waits, input logic run_next, input logic mid_run);
        cyc_t e;
        logic [4:0] op;
        logic [15:0] ra, rb, rc;
        op = i[31:27];
        ra = 16'd1 << i[26:23];
        rb = 16'd1 << i[22:19];
        rc = 16'd1 << i[18:15];
        e = blk(mid_run, $urandom);
        e.f[PCOUT] = 1; e.f[MARIN] = 1; e.f[INCPC] = 1; e.f[ZIN] = 1;
        exp_q.push_back(e);
        for (int w = 0; w <= waits; w++) begin
            e = blk(mid_run, $urandom);
            e.mrdy = (w == waits);
            e.f[ZLO] = 1; e.f[PCIN] = 1; e.f[READ] = 1; e.f[MDRIN] = 1;
            exp_q.push_back(e);
        end
        e = blk(mid_run, $urandom);
        e.f[MDROUT] = 1; e.f[IRIN] = 1;
        exp_q.push_back(e);
        e = blk(mid_run, i);
        case (cls(op))
            0: begin
                e.rout = rb; e.f[YIN] = 1; exp_q.push_back(e);
                e = blk(mid_run, i); e.rout = rc; e.alu = op; e.f[ZIN] = 1; exp_q.push_back(e);
                e = blk(mid_run, i); e.f[ZLO] = 1; e.rin = ra; e.f[DONE] = 1; exp_q.push_back(e);
            end
            1: begin
                e.rout = ra; e.f[YIN] = 1; exp_q.push_back(e);
                e = blk(mid_run, i); e.rout = rb; e.alu = op; e.f[ZIN] = 1; exp_q.push_back(e);
                e = blk(mid_run, i); e.f[ZLO] = 1; e.f[LOIN] = 1; exp_q.push_back(e);
                e = blk(mid_run, i); e.f[ZHI] = 1; e.f[HIIN] = 1; e.f[DONE] = 1; exp_q.push_back(e);
            end
            2: begin
                e.rout = rb; e.alu = op; e.f[ZIN] = 1; exp_q.push_back(e);
                e = blk(mid_run, i); e.f[ZLO] = 1; e.rin = ra; e.f[DONE] = 1; exp_q.push_back(e);
            end
            3: begin
                e.f[DONE] = 1; exp_q.push_back(e);
            end
            default: begin
                exp_q.push_back(e);
                return;
            end
        endcase
        exp_q.push_back(blk(run_next, $urandom));
    endtask
    task automatic run_seq(input int n);
        cyc_t e;
        int cyc = 0;
        int t0 = 0;
        rd_cnt = 0;
        while (exp_q.size() > 0 && cyc < n) begin
            e = exp_q.pop_front();
            @(negedge clk);
            run = e.run; mrdy = e.mrdy; ir = e.ir;
            #1;
            cyc++;
            checks++;
            if (flags() !== e.f) begin
                errors++;
                $display("FAIL strobes cyc %0d: got %b want %b", cyc, flags(), e.f);
            end
            checks++;
            if ({rin, rout, alu_op} !== {e.rin, e.rout, e.alu}) begin
                errors++;
                $display("FAIL regsel cyc %0d: got rin=%h rout=%h alu=%b want rin=%h rout=%h alu=%b",
                         cyc, rin, rout, alu_op, e.rin, e.rout, e.alu);
            end
            checks++;
            if ({halted, illegal} !== {e.halted, e.ill}) begin
                errors++;
                $display("FAIL status cyc %0d: got halted=%b illegal=%b want %b %b",
                         cyc, halted, illegal, e.halted, e.ill);
            end
            checks++;
            if ($countones({pcout, zhighout, zlowout, mdrout, hiout, loout, rout}) > 1) begin
                errors++;
                $display("FAIL bus_single_driver cyc %0d: got %0d drivers want <=1", cyc,
                         $countones({pcout, zhighout, zlowout, mdrout, hiout, loout, rout}));
            end
            if (pcout && marin) t0 = cyc;
            if (done) last_lat = cyc - t0 + 1;
            if (read) rd_cnt++;
        end
    endtask
    task automatic check_lat(input string name, input int want);
        checks++;
        if (last_lat != want) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, last_lat, want);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run = 1'($urandom);
        #1;
        checks++;
        if (all_out() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_out());
        end
        @(negedge clk);
        run = 1'b0;
        rst_n = 1'b1;
        push_idle(2, 1'b0);
        run_seq(1000);
    endtask
    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_out() !== '0) begin
            errors++;
            $display("FAIL power_on_reset: got %h want 0", all_out());
        end
        rst_n = 1'b1;
        push_idle(3, 1'b0);
        run_seq(1000);
    endtask
    task automatic test_and();
        push_idle(1, 1'b1);
        add_instr(IR_AND, 0, 1'b0, 1'b1);
        push_idle(2, 1'b0);
        run_seq(1000);
        check_lat("and", 6);
    endtask
    task automatic test_mul();
        push_idle(1, 1'b1);
        add_instr(IR_MUL, 0, 1'b0, 1'b1);
        push_idle(2, 1'b0);
        run_seq(1000);
        check_lat("mul", 7);
    endtask
    task automatic test_mem_wait();
        push_idle(1, 1'b1);
        add_instr(IR_NEG, 3, 1'b0, 1'b1);
        push_idle(2, 1'b0);
        run_seq(1000);
        check_lat("neg_wait3", 8);
        checks++;
        if (rd_cnt != 4) begin
            errors++;
            $display("FAIL read_cycles: got %0d want 4", rd_cnt);
        end
    endtask
    task automatic test_back_to_back();
        push_idle(1, 1'b1);
        add_instr(IR_AND, 0, 1'b1, 1'b1);
        add_instr(IR_NOP, 0, 1'b0, 1'b1);
        push_idle(2, 1'b0);
        run_seq(1000);
        check_lat("nop", 4);
    endtask
    task automatic test_run_drop();
        push_idle(1, 1'b1);
        add_instr(IR_AND, 0, 1'b0, 1'b0);
        push_idle(4, 1'b0);
        run_seq(1000);
        check_lat("and_run_drop", 6);
    endtask
    task automatic test_illegal();
        push_idle(1, 1'b1);
        add_instr({5'b11111, 27'($urandom)}, 1, 1'b1, 1'b1);
        push_halt(6, 1'b1);
        run_seq(1000);
        do_reset();
    endtask
    task automatic test_halt();
        push_idle(1, 1'b1);
        add_instr({5'b11011, 27'($urandom)}, 0, 1'b1, 1'b1);
        push_halt(4, 1'b0);
        run_seq(1000);
        do_reset();
    endtask
    task automatic test_reset_mid();
        push_idle(1, 1'b1);
        add_instr(IR_AND, 1, 1'b1, 1'b1);
        run_seq(6);
        exp_q.delete();
        @(negedge clk);
        #1;
        checks++;
        if ({zin, rout, alu_op} !== {1'b1, 16'h0008, 5'b00101}) begin
            errors++;
            $display("FAIL mid_t4: got zin=%b rout=%h alu=%b want 1 0008 00101", zin, rout, alu_op);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_out() !== '0) begin
            errors++;
            $display("FAIL async_reset_t4: got %h want 0", all_out());
        end
        @(negedge clk);
        run = 1'b0;
        rst_n = 1'b1;
        push_idle(3, 1'b0);
        run_seq(1000);
    endtask
    task automatic test_random();
        logic [4:0] ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                 5'd15, 5'd16, 5'd17, 5'd18, 5'd26};
        push_idle(1, 1'b1);
        for (int k = 0; k < 24; k++)
            add_instr({ops[$urandom_range(0, 12)], 27'($urandom)}, $urandom_range(0, 3),
                      k < 23, 1'($urandom));
        push_idle(3, 1'b0);
        run_seq(5000);
    endtask
    initial begin
        test_reset();
        test_and();
        test_mul();
        test_mem_wait();
        test_back_to_back();
        test_run_drop();
        test_reset_mid();
        test_illegal();
        test_halt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
